// File: rtl/vga_axis_pkg.sv
// Shared types and field layout for the raster-to-stream converter.
// FIFO entry = {user, last, data}; FSM states for frame sync.
package vga_axis_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ENTRY_W    = DATA_W_DEF + 2;
  localparam int DATA_LSB   = 0;

  function automatic int entry_w(int dw);
    return dw + 2;
  endfunction

  function automatic int last_idx(int dw);
    return dw;
  endfunction

  function automatic int user_idx(int dw);
    return dw + 1;
  endfunction

  typedef enum logic {
    WAIT_SOF = 1'b0,
    ACTIVE   = 1'b1
  } state_t;

endpackage

// File: rtl/vga2axi_fifo.sv
// First-word-fall-through FIFO: ACLK/ARESTN, push/wdata in, pop in,
// rdata/empty out, sticky overflow on dropped push, level occupancy.
module vga2axi_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 16
) (
  input  logic                     ACLK,
  input  logic                     ARESTN,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     empty,
  output logic                     overflow,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign empty   = (level == '0);
  assign full    = (level == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  // a full FIFO still accepts a push when the head leaves the same cycle
  assign do_push = push && (!full || do_pop);
  assign rdata   = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge ACLK) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge ACLK or negedge ARESTN) begin
    if (!ARESTN) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: ;
      endcase
      if (push && !do_push) overflow <= 1'b1;
    end
  end

endmodule

// File: rtl/vga2axi_stream.sv
// Raster (VS/DE/PIXEL) to AXI4-Stream video: TUSER=SOF, TLAST=EOL.
// Ports: ACLK, ARESTN, VS, DE, PIXEL in; TDATA/TUSER/TLAST/TVALID/TSTRB out, TREADY in, OVERFLOW, LEVEL.
module vga2axi_stream
  import vga_axis_pkg::*;
#(
  parameter int DATA_W        = 8,
  parameter int FIFO_DEPTH    = 16,
  parameter bit VS_ACTIVE_LOW = 1'b1
) (
  input  logic                          ACLK,
  input  logic                          ARESTN,
  input  logic                          VS,
  input  logic                          DE,
  input  logic [DATA_W-1:0]             PIXEL,
  output logic [DATA_W-1:0]             TDATA,
  output logic                          TUSER,
  output logic                          TLAST,
  output logic                          TVALID,
  input  logic                          TREADY,
  output logic                          TSTRB,
  output logic                          OVERFLOW,
  output logic [$clog2(FIFO_DEPTH):0]   LEVEL
);

  localparam int   EW      = entry_w(DATA_W);
  localparam int   UI      = user_idx(DATA_W);
  localparam int   LI      = last_idx(DATA_W);
  localparam logic VS_IDLE = VS_ACTIVE_LOW ? 1'b1 : 1'b0;

  state_t            state;
  logic              vs_r;
  logic              vs_d;
  logic              de_r;
  logic [DATA_W-1:0] pix_r;
  logic              hold_v;
  logic              hold_user;
  logic [DATA_W-1:0] hold_data;
  logic              sof_pending;
  logic              sof;
  logic              push;
  logic              push_last;
  logic [EW-1:0]     push_entry;
  logic [EW-1:0]     head;
  logic              empty;

  assign sof = (vs_r != VS_IDLE) && (vs_d == VS_IDLE);

  // the held pixel closes its line when DE drops or a new frame
  // starts under it; otherwise the next pixel proves it is not last
  assign push      = (state == ACTIVE) && hold_v;
  assign push_last = !de_r || sof;

  always_comb begin
    push_entry            = '0;
    push_entry[UI]        = hold_user;
    push_entry[LI]        = push_last;
    push_entry[DATA_W-1:0] = hold_data;
  end

  always_ff @(posedge ACLK or negedge ARESTN) begin
    if (!ARESTN) begin
      vs_r        <= VS_IDLE;
      vs_d        <= VS_IDLE;
      de_r        <= 1'b0;
      pix_r       <= '0;
      state       <= WAIT_SOF;
      hold_v      <= 1'b0;
      hold_user   <= 1'b0;
      hold_data   <= '0;
      sof_pending <= 1'b0;
    end else begin
      vs_r  <= VS;
      vs_d  <= vs_r;
      de_r  <= DE;
      pix_r <= PIXEL;
      unique case (state)
        WAIT_SOF: begin
          if (sof) begin
            state       <= ACTIVE;
            sof_pending <= 1'b1;
          end
        end
        ACTIVE: begin
          if (de_r) begin
            hold_v      <= 1'b1;
            hold_data   <= pix_r;
            hold_user   <= sof_pending || sof;
            sof_pending <= 1'b0;
          end else begin
            hold_v <= 1'b0;
            if (sof) sof_pending <= 1'b1;
          end
        end
        default: state <= WAIT_SOF;
      endcase
    end
  end

  vga2axi_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .ACLK     (ACLK),
    .ARESTN   (ARESTN),
    .push     (push),
    .wdata    (push_entry),
    .pop      (TREADY),
    .rdata    (head),
    .empty    (empty),
    .overflow (OVERFLOW),
    .level    (LEVEL)
  );

  assign TVALID = !empty;
  assign TDATA  = head[DATA_W-1:0];
  assign TUSER  = head[UI];
  assign TLAST  = head[LI];
  assign TSTRB  = 1'b1;

endmodule

// File: tb/tb_vga2axi_stream.sv
// Bench for vga2axi_stream: line/frame reference model vs observed beats.
// DUT built with DATA_W=8, FIFO_DEPTH=4, VS active low.
module tb_vga2axi_stream;

  logic       ACLK = 1'b0;
  logic       ARESTN = 1'b0;
  logic       VS = 1'b1;
  logic       DE = 1'b0;
  logic [7:0] PIXEL = 8'h00;
  logic       TREADY = 1'b0;
  logic [7:0] TDATA;
  logic       TUSER;
  logic       TLAST;
  logic       TVALID;
  logic       TSTRB;
  logic       OVERFLOW;
  logic [2:0] LEVEL;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int tvalid_cnt = 0;

  logic [9:0] exp_q[$];
  logic [9:0] obs_q[$];
  int         obs_cyc[$];
  logic [8:0] m_line[$];
  logic       m_sync;
  logic       m_pend;
  logic       m_prev_vs;
  logic       cur_vs;

  vga2axi_stream #(
    .DATA_W        (8),
    .FIFO_DEPTH    (4),
    .VS_ACTIVE_LOW (1'b1)
  ) dut (
    .ACLK     (ACLK),
    .ARESTN   (ARESTN),
    .VS       (VS),
    .DE       (DE),
    .PIXEL    (PIXEL),
    .TDATA    (TDATA),
    .TUSER    (TUSER),
    .TLAST    (TLAST),
    .TVALID   (TVALID),
    .TREADY   (TREADY),
    .TSTRB    (TSTRB),
    .OVERFLOW (OVERFLOW),
    .LEVEL    (LEVEL)
  );

  always #5 ACLK = ~ACLK;

  always @(posedge ACLK) cyc <= cyc + 1;

  always @(negedge ACLK) begin
    if (ARESTN && TVALID) tvalid_cnt <= tvalid_cnt + 1;
    if (ARESTN && TVALID && TREADY) begin
      obs_q.push_back({TUSER, TLAST, TDATA});
      obs_cyc.push_back(cyc);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model: lines and frames ----------------
  task automatic model_reset();
    m_line.delete();
    exp_q.delete();
    obs_q.delete();
    obs_cyc.delete();
    m_sync = 1'b0;
    m_pend = 1'b0;
    m_prev_vs = 1'b1;
    tvalid_cnt = 0;
  endtask

  task automatic flush_line();
    int n;
    n = m_line.size();
    for (int j = 0; j < n; j++)
      exp_q.push_back({m_line[j][8], j == n - 1, m_line[j][7:0]});
    m_line.delete();
  endtask

  task automatic model_step(input logic vs, input logic de,
                            input logic [7:0] pix);
    logic sof;
    logic was;
    sof = m_prev_vs && !vs;
    was = m_sync;
    if (sof) begin
      flush_line();
      m_sync = 1'b1;
      m_pend = 1'b1;
    end
    if (de && was) begin
      m_line.push_back({m_pend, pix});
      m_pend = 1'b0;
    end
    if (!de) flush_line();
    m_prev_vs = vs;
  endtask

  // one input cycle; returns #1 after the edge that samples it
  task automatic drive(input logic vs, input logic de,
                       input logic [7:0] pix, input logic rdy);
    VS = vs;
    DE = de;
    PIXEL = pix;
    TREADY = rdy;
    cur_vs = vs;
    model_step(vs, de, pix);
    @(posedge ACLK);
    #1;
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) drive(cur_vs, 1'b0, 8'h00, rdy);
  endtask

  task automatic drain(input int maxc);
    for (int n = 0; n < maxc && obs_q.size() < exp_q.size(); n++)
      drive(cur_vs, 1'b0, 8'h00, 1'b1);
    idle(4, 1'b1);
  endtask

  task automatic do_reset();
    ARESTN = 1'b0;
    VS = 1'b1;
    cur_vs = 1'b1;
    DE = 1'b0;
    PIXEL = 8'h00;
    TREADY = 1'b0;
    repeat (2) @(posedge ACLK);
    #1;
    ARESTN = 1'b1;
    model_reset();
  endtask

  task automatic start_frame(input logic rdy);
    drive(1'b1, 1'b0, 8'h00, rdy);
    drive(1'b1, 1'b0, 8'h00, rdy);
    drive(1'b0, 1'b0, 8'h00, rdy);
    drive(1'b0, 1'b0, 8'h00, rdy);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    ARESTN = 1'b0;
    #2;
    checks++;
    if (TVALID !== 1'b0) begin
      failures++;
      $display("FAIL rst_tvalid got=%0b exp=0", TVALID);
    end
    checks++;
    if ({TUSER, TLAST, TDATA} !== 10'h000) begin
      failures++;
      $display("FAIL rst_data got=%0h exp=0", {TUSER, TLAST, TDATA});
    end
    checks++;
    if (OVERFLOW !== 1'b0 || LEVEL !== 3'd0) begin
      failures++;
      $display("FAIL rst_ovf_lvl got=%0b/%0d exp=0/0", OVERFLOW, LEVEL);
    end
    checks++;
    if (TSTRB !== 1'b1) begin
      failures++;
      $display("FAIL tstrb got=%0b exp=1", TSTRB);
    end
    do_reset();
  endtask

  task automatic test_frame_start();
    int t10;
    int d0;
    do_reset();
    start_frame(1'b1);
    t10 = 0;
    d0 = 0;
    for (int l = 0; l < 2; l++) begin
      for (int p = 0; p < 4; p++) begin
        if (l == 0 && p == 0) t10 = cyc;
        drive(1'b0, 1'b1, 8'(8'h10 + l * 4 + p), 1'b1);
      end
      if (l == 0) d0 = cyc;
      idle(3, 1'b1);
    end
    drain(40);
    checks++;
    if (obs_q.size() != 8 || exp_q.size() != 8) begin
      failures++;
      $display("FAIL fs_count got=%0d exp=8", obs_q.size());
    end
    for (int i = 0; i < 8 && i < obs_q.size(); i++) begin
      logic [9:0] e;
      e = {i == 0, i == 3 || i == 7, 8'(8'h10 + i)};
      checks++;
      if (obs_q[i] !== e) begin
        failures++;
        $display("FAIL fs_beat%0d got=%0h exp=%0h", i, obs_q[i], e);
      end
    end
    if (obs_q.size() >= 4) begin
      checks++;
      if (obs_cyc[0] - t10 != 3) begin
        failures++;
        $display("FAIL fs_lat_first got=%0d exp=3", obs_cyc[0] - t10);
      end
      checks++;
      if (obs_cyc[3] - d0 != 2) begin
        failures++;
        $display("FAIL fs_lat_last got=%0d exp=2", obs_cyc[3] - d0);
      end
    end
  endtask

  task automatic test_presync();
    do_reset();
    drive(1'b1, 1'b1, 8'hAA, 1'b1);
    drive(1'b1, 1'b1, 8'hBB, 1'b1);
    idle(6, 1'b1);
    checks++;
    if (tvalid_cnt != 0 || LEVEL !== 3'd0) begin
      failures++;
      $display("FAIL presync_discard got=%0d/%0d exp=0/0",
               tvalid_cnt, LEVEL);
    end
    drive(1'b0, 1'b0, 8'h00, 1'b1);
    drive(1'b0, 1'b0, 8'h00, 1'b1);
    drive(1'b0, 1'b1, 8'h55, 1'b1);
    idle(3, 1'b1);
    drain(20);
    checks++;
    if (obs_q.size() != 1) begin
      failures++;
      $display("FAIL presync_count got=%0d exp=1", obs_q.size());
    end
    if (obs_q.size() >= 1 && exp_q.size() >= 1) begin
      checks++;
      if (obs_q[0] !== 10'h355 || obs_q[0] !== exp_q[0]) begin
        failures++;
        $display("FAIL presync_beat got=%0h exp=355", obs_q[0]);
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    start_frame(1'b0);
    for (int i = 0; i < 6; i++)
      drive(1'b0, 1'b1, 8'($urandom), 1'b0);
    idle(3, 1'b0);
    checks++;
    if (LEVEL !== 3'd4 || OVERFLOW !== 1'b1) begin
      failures++;
      $display("FAIL bp_full got=%0d/%0b exp=4/1", LEVEL, OVERFLOW);
    end
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (TVALID !== 1'b1 || {TUSER, TLAST, TDATA} !== exp_q[0]) begin
        failures++;
        $display("FAIL bp_stable got=%0h exp=%0h",
                 {TUSER, TLAST, TDATA}, exp_q[0]);
      end
      idle(1, 1'b0);
    end
    while (exp_q.size() > 4) void'(exp_q.pop_back());
    drain(30);
    checks++;
    if (obs_q.size() != 4) begin
      failures++;
      $display("FAIL bp_count got=%0d exp=4", obs_q.size());
    end
    for (int i = 0; i < 4 && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL bp_beat%0d got=%0h exp=%0h", i, obs_q[i], exp_q[i]);
      end
    end
    if (obs_q.size() >= 4) begin
      checks++;
      if (obs_q[3][8] !== 1'b0) begin
        failures++;
        $display("FAIL bp_last4 got=%0b exp=0", obs_q[3][8]);
      end
    end
    checks++;
    if (OVERFLOW !== 1'b1) begin
      failures++;
      $display("FAIL bp_sticky got=%0b exp=1", OVERFLOW);
    end
  endtask

  task automatic test_full_pop();
    logic rdy;
    logic used;
    do_reset();
    start_frame(1'b0);
    rdy = 1'b0;
    for (int i = 0; i < 12; i++) begin
      used = rdy;
      drive(1'b0, 1'b1, 8'($urandom), rdy);
      if (used) begin
        checks++;
        if (LEVEL !== 3'd4 || OVERFLOW !== 1'b0) begin
          failures++;
          $display("FAIL fp_level got=%0d/%0b exp=4/0", LEVEL, OVERFLOW);
        end
      end
      if (LEVEL == 3'd4) rdy = 1'b1;
    end
    checks++;
    if (rdy !== 1'b1) begin
      failures++;
      $display("FAIL fp_reach4 got=%0d exp=4", LEVEL);
    end
    idle(3, 1'b1);
    drain(40);
    checks++;
    if (obs_q.size() != 12 || OVERFLOW !== 1'b0) begin
      failures++;
      $display("FAIL fp_count got=%0d/%0b exp=12/0", obs_q.size(), OVERFLOW);
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL fp_beat%0d got=%0h exp=%0h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_malformed();
    do_reset();
    start_frame(1'b1);
    drive(1'b1, 1'b0, 8'h00, 1'b1);
    drive(1'b1, 1'b0, 8'h00, 1'b1);
    drive(1'b1, 1'b1, 8'hA1, 1'b1);
    drive(1'b1, 1'b1, 8'hB2, 1'b1);
    drive(1'b0, 1'b1, 8'hC3, 1'b1);
    drive(1'b0, 1'b1, 8'hD4, 1'b1);
    drive(1'b0, 1'b1, 8'hE5, 1'b1);
    idle(3, 1'b1);
    drain(30);
    checks++;
    if (obs_q.size() != 5 || exp_q.size() != 5) begin
      failures++;
      $display("FAIL mal_count got=%0d exp=5", obs_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL mal_beat%0d got=%0h exp=%0h", i, obs_q[i], exp_q[i]);
      end
    end
    if (obs_q.size() >= 3) begin
      checks++;
      if (obs_q[1] !== 10'h1B2 || obs_q[2] !== 10'h2C3) begin
        failures++;
        $display("FAIL mal_split got=%0h/%0h exp=1b2/2c3",
                 obs_q[1], obs_q[2]);
      end
    end
  endtask

  task automatic test_random();
    int len;
    int gap;
    logic r;
    do_reset();
    start_frame(1'b1);
    for (int f = 0; f < 3; f++) begin
      if (f > 0) begin
        drive(1'b1, 1'b0, 8'h00, 1'b1);
        drive(1'b1, 1'b0, 8'h00, 1'b1);
        drive(1'b0, 1'b0, 8'h00, 1'b1);
      end
      for (int l = 0; l < 4; l++) begin
        len = $urandom_range(1, 3);
        for (int p = 0; p < len; p++) begin
          r = (cyc % 2 == 0) ? 1'b1 : 1'($urandom);
          drive(1'b0, 1'b1, 8'($urandom), r);
        end
        gap = $urandom_range(8, 10);
        for (int g = 0; g < gap; g++) begin
          r = (cyc % 2 == 0) ? 1'b1 : 1'($urandom);
          drive(1'b0, 1'b0, 8'h00, r);
        end
      end
    end
    drain(80);
    checks++;
    if (obs_q.size() != exp_q.size() || OVERFLOW !== 1'b0) begin
      failures++;
      $display("FAIL rnd_count got=%0d exp=%0d ovf=%0b",
               obs_q.size(), exp_q.size(), OVERFLOW);
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL rnd_beat%0d got=%0h exp=%0h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_reset_midframe();
    do_reset();
    start_frame(1'b0);
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 8'($urandom), 1'b0);
    idle(3, 1'b0);
    drive(1'b0, 1'b1, 8'h61, 1'b0);
    drive(1'b0, 1'b1, 8'h62, 1'b0);
    checks++;
    if (LEVEL !== 3'd3) begin
      failures++;
      $display("FAIL mr_prelevel got=%0d exp=3", LEVEL);
    end
    ARESTN = 1'b0;
    VS = 1'b1;
    PIXEL = 8'h63;
    #1;
    checks++;
    if (TVALID !== 1'b0 || LEVEL !== 3'd0 || OVERFLOW !== 1'b0) begin
      failures++;
      $display("FAIL mr_async got=%0b/%0d/%0b exp=0/0/0",
               TVALID, LEVEL, OVERFLOW);
    end
    repeat (2) @(posedge ACLK);
    #1;
    ARESTN = 1'b1;
    model_reset();
    cur_vs = 1'b1;
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b1, 8'($urandom), 1'b1);
    idle(6, 1'b1);
    checks++;
    if (tvalid_cnt != 0) begin
      failures++;
      $display("FAIL mr_ignore got=%0d exp=0", tvalid_cnt);
    end
    drive(1'b0, 1'b0, 8'h00, 1'b1);
    drive(1'b0, 1'b0, 8'h00, 1'b1);
    drive(1'b0, 1'b1, 8'h71, 1'b1);
    drive(1'b0, 1'b1, 8'h72, 1'b1);
    idle(3, 1'b1);
    drain(30);
    checks++;
    if (obs_q.size() != 2 || exp_q.size() != 2) begin
      failures++;
      $display("FAIL mr_count got=%0d exp=2", obs_q.size());
    end
    if (obs_q.size() >= 2) begin
      checks++;
      if (obs_q[0] !== 10'h271 || obs_q[1] !== 10'h172) begin
        failures++;
        $display("FAIL mr_beats got=%0h/%0h exp=271/172",
                 obs_q[0], obs_q[1]);
      end
    end
  endtask

  initial begin
    model_reset();
    cur_vs = 1'b1;
    test_reset();
    test_frame_start();
    test_presync();
    test_backpressure();
    test_full_pop();
    test_malformed();
    test_random();
    test_reset_midframe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
